sim_data_mem: RTL and testbench

//  Parametrised behavioural data-memory slave for CPU testbenches. It is the next

---
 rtl/sim_data_mem.sv | 153 +++++++++++++++
 tb/tb_sim_data_mem.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sim_data_mem.sv
// sim_data_mem: behavioural data-memory slave for CPU testbenches.
// It sits on the CPU data-bus slave side and answers read and write
// requests after a configurable number of stall cycles. Writes are
// byte-masked, and completed reads and writes are counted for bench checks.
// This model is for simulation only.
module sim_data_mem #(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 32,
  parameter int    MEM_WORDS = 8192,
  parameter int    READ_LAT  = 1,
  parameter int    WRITE_LAT = 0,
  parameter string INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   address,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W/8-1:0] mask,
  input  logic [DATA_W-1:0]   data_wr,
  output logic [DATA_W-1:0]   data_rd,
  output logic                stall,
  output logic [31:0]         rd_count,
  output logic [31:0]         wr_count
);

  localparam int         BYTES = DATA_W / 8;
  localparam int         OFS_W = $clog2(BYTES);
  localparam int         IDX_W = $clog2(MEM_WORDS);
  localparam logic [3:0] RD_L  = 4'(READ_LAT);
  localparam logic [3:0] WR_L  = 4'(WRITE_LAT);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state;
  logic [3:0]        count;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_wr;

  logic [DATA_W-1:0] mem      [MEM_WORDS] = '{default: '0};

  logic              req;
  logic [IDX_W-1:0]  cur_idx;
  logic [IDX_W-1:0]  lat_idx;
  logic [IDX_W-1:0]  commit_idx;
  logic [3:0]        cur_lat;
  logic [3:0]        held_lat;
  logic              rd_done;
  logic              wr_done;
  logic [DATA_W-1:0] merged;

  // A write outranks a read when both are raised. Upper address bits wrap.
  assign req      = read | write;
  assign cur_idx  = address[OFS_W +: IDX_W];
  assign lat_idx  = lat_addr[OFS_W +: IDX_W];
  assign cur_lat  = write ? WR_L : RD_L;
  assign held_lat = lat_wr ? WR_L : RD_L;

  // This block decodes the completion strobes, stall and read data for the current cycle.
  always_comb begin
    stall      = 1'b0;
    data_rd    = '0;
    rd_done    = 1'b0;
    wr_done    = 1'b0;
    commit_idx = cur_idx;
    if (rst) begin
      unique case (state)
        IDLE: begin
          if (req) begin
            if (cur_lat == 4'd0) begin
              if (write) begin
                wr_done = 1'b1;
              end else begin
                rd_done = 1'b1;
                data_rd = mem[cur_idx];
              end
            end else begin
              stall = 1'b1;
            end
          end
        end
        WAIT: begin
          stall = 1'b1;
        end
        DONE: begin
          commit_idx = lat_idx;
          if (lat_wr) begin
            wr_done = 1'b1;
          end else begin
            rd_done = 1'b1;
            data_rd = mem[lat_idx];
          end
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end
  end

  // This block overlays the enabled bytes of the write data on the stored word that is about to be committed.
  always_comb begin
    merged = mem[commit_idx];
    for (int b = 0; b < BYTES; b++) begin
      if (mask[b]) merged[8*b +: 8] = data_wr[8*b +: 8];
    end
  end

  // This block runs the latency FSM and the completion counters. A changed or dropped request aborts the transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= 4'd0;
      lat_addr <= '0;
      lat_wr   <= 1'b0;
      rd_count <= 32'd0;
      wr_count <= 32'd0;
    end else begin
      if (rd_done) rd_count <= rd_count + 32'd1;
      if (wr_done) wr_count <= wr_count + 32'd1;
      unique case (state)
        IDLE: begin
          if (req && (cur_lat != 4'd0)) begin
            lat_addr <= address;
            lat_wr   <= write;
            count    <= 4'd1;
            state    <= (cur_lat == 4'd1) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (!req || (address != lat_addr) || (write != lat_wr)) begin
            state <= IDLE;
          end else begin
            count <= count + 4'd1;
            if ((count + 4'd1) == held_lat) state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // This block commits each completed write as the merged word.
  always_ff @(posedge clk) begin
    if (wr_done) mem[commit_idx] <= merged;
  end

endmodule

// File: tb/tb_sim_data_mem.sv
// tb_sim_data_mem: bench for two sim_data_mem instances with different latencies.
// Instance A uses READ_LAT=1, WRITE_LAT=0 and 8192 words.
// Instance B uses READ_LAT=3, WRITE_LAT=2 and 1024 words.
// A reference memory and a pair of counters per instance supply every expected value.
module tb_sim_data_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [31:0] address;
  logic [31:0] data_wr;
  logic [3:0]  mask;
  logic        read;
  logic        write;

  logic        a_read, a_write, b_read, b_write;
  logic [31:0] a_data_rd, b_data_rd;
  logic        a_stall, b_stall;
  logic [31:0] a_rd_count, a_wr_count, b_rd_count, b_wr_count;

  logic        cur_stall;
  logic [31:0] cur_data_rd, cur_rd_count, cur_wr_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [2][8192];
  logic [31:0] exp_rd [2];
  logic [31:0] exp_wr [2];
  int          rlat  [2] = '{1, 3};
  int          wlat  [2] = '{0, 2};
  int          words [2] = '{8192, 1024};

  logic [31:0] rdata;

  always #5 clk = ~clk;

  // The shared request lines go only to the selected instance, and that instance's outputs are observed.
  assign a_read       = read & ~sel;
  assign a_write      = write & ~sel;
  assign b_read       = read & sel;
  assign b_write      = write & sel;
  assign cur_stall    = sel ? b_stall : a_stall;
  assign cur_data_rd  = sel ? b_data_rd : a_data_rd;
  assign cur_rd_count = sel ? b_rd_count : a_rd_count;
  assign cur_wr_count = sel ? b_wr_count : a_wr_count;

  sim_data_mem #(
    .DATA_W(32), .ADDR_W(32), .MEM_WORDS(8192), .READ_LAT(1), .WRITE_LAT(0), .INIT_FILE("")
  ) u_a (
    .clk(clk), .rst(rst), .address(address), .read(a_read), .write(a_write),
    .mask(mask), .data_wr(data_wr), .data_rd(a_data_rd), .stall(a_stall),
    .rd_count(a_rd_count), .wr_count(a_wr_count)
  );

  sim_data_mem #(
    .DATA_W(32), .ADDR_W(32), .MEM_WORDS(1024), .READ_LAT(3), .WRITE_LAT(2), .INIT_FILE("")
  ) u_b (
    .clk(clk), .rst(rst), .address(address), .read(b_read), .write(b_write),
    .mask(mask), .data_wr(data_wr), .data_rd(b_data_rd), .stall(b_stall),
    .rd_count(b_rd_count), .wr_count(b_wr_count)
  );

  // Compares one observed value with its expected value and records any failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic int model_idx(input int s, input logic [31:0] addr);
    return int'((addr / 32'd4) % 32'(words[s]));
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] m);
    logic [31:0] lanes;
    lanes = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return (old_w & ~lanes) | (new_w & lanes);
  endfunction

  // Runs one transaction while the request is held. It counts the stall cycles and captures the completion data.
  // It then checks the result against the reference model and updates the model.
  task automatic applyStimulus(input int s, input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] msk, input string tag,
                               output logic [31:0] got);
    int          stalls;
    bit          done;
    int          lat;
    int          idx;
    logic [31:0] exp_data;
    idx      = model_idx(s, addr);
    lat      = wr ? wlat[s] : rlat[s];
    exp_data = (rd && !wr) ? model_mem[s][idx] : 32'd0;
    got      = 'x;
    @(posedge clk); #1;
    sel = s[0]; address = addr; data_wr = data; mask = msk; read = rd; write = wr;
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (cur_stall) stalls++;
      else begin
        done = 1'b1;
        got  = cur_data_rd;
      end
    end
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    checkOutput($sformatf("%s stall_cycles", tag), 32'(stalls), 32'(lat));
    checkOutput($sformatf("%s data_rd", tag), got, exp_data);
    if (wr) begin
      model_mem[s][idx] = lane_merge(model_mem[s][idx], data, msk);
      exp_wr[s] = exp_wr[s] + 32'd1;
    end else if (rd) begin
      exp_rd[s] = exp_rd[s] + 32'd1;
    end
    @(negedge clk);
    checkOutput($sformatf("%s rd_count", tag), cur_rd_count, exp_rd[s]);
    checkOutput($sformatf("%s wr_count", tag), cur_wr_count, exp_wr[s]);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 8192; i++) model_mem[s][i] = 32'd0;
      exp_rd[s] = 32'd0;
      exp_wr[s] = 32'd0;
    end

    $display("[TB] reset with a read held on A");
    rst = 1'b0; sel = 1'b0; address = 32'h10; data_wr = 32'd0; mask = 4'h0; read = 1'b1; write = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset a_stall", {31'd0, a_stall}, 32'd0);
    checkOutput("reset a_data_rd", a_data_rd, 32'd0);
    checkOutput("reset a_rd_count", a_rd_count, 32'd0);
    checkOutput("reset a_wr_count", a_wr_count, 32'd0);
    checkOutput("reset b_stall", {31'd0, b_stall}, 32'd0);
    checkOutput("reset b_rd_count", b_rd_count, 32'd0);
    read = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] directed transactions on A");
    applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "a_wr10", rdata);
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, "a_rd10", rdata);
    checkOutput("a_rd10 const", rdata, 32'hDEADBEEF);
    applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, "a_wr20", rdata);
    applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, "a_wr20_mask", rdata);
    applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, "a_rd20", rdata);
    checkOutput("a_rd20 const", rdata, 32'h11BB33DD);
    applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, "a_wr20_nomask", rdata);
    applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, "a_rd20_again", rdata);
    checkOutput("a_rd20_again const", rdata, 32'h11BB33DD);
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_8004, 32'hCAFEF00D, 4'hF, "a_wr_wrap", rdata);
    applyStimulus(0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, "a_rd_wrap", rdata);
    checkOutput("a_rd_wrap const", rdata, 32'hCAFEF00D);
    applyStimulus(0, 1'b1, 1'b1, 32'h40, 32'h5A5A5A5A, 4'hF, "a_both40", rdata);
    applyStimulus(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, "a_rd40", rdata);

    $display("[TB] directed transactions on B");
    applyStimulus(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, "b_rd10", rdata);
    applyStimulus(1, 1'b0, 1'b1, 32'h30, 32'h12345678, 4'hF, "b_wr30", rdata);
    applyStimulus(1, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, "b_rd30", rdata);

    $display("[TB] held read on B spans two transactions");
    @(posedge clk); #1;
    sel = 1'b1; address = 32'h30; read = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput($sformatf("held_read stall[%0d]", i), {31'd0, b_stall}, (i % 4 == 3) ? 32'd0 : 32'd1);
      checkOutput($sformatf("held_read data[%0d]", i), b_data_rd,
                  (i % 4 == 3) ? model_mem[1][model_idx(1, 32'h30)] : 32'd0);
    end
    @(posedge clk); #1;
    read = 1'b0;
    exp_rd[1] = exp_rd[1] + 32'd2;
    @(negedge clk);
    checkOutput("held_read rd_count", b_rd_count, exp_rd[1]);

    $display("[TB] write dropped mid-latency on B");
    @(posedge clk); #1;
    sel = 1'b1; address = 32'h30; data_wr = 32'hFFFF0000; mask = 4'hF; write = 1'b1;
    @(negedge clk);
    checkOutput("abort first stall", {31'd0, b_stall}, 32'd1);
    @(posedge clk); #1;
    write = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort wr_count", b_wr_count, exp_wr[1]);
    applyStimulus(1, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, "abort_rd30", rdata);

    $display("[TB] reset pulsed mid-latency on B");
    @(posedge clk); #1;
    sel = 1'b1; address = 32'h30; data_wr = 32'hDEAD0000; mask = 4'hF; write = 1'b1;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    checkOutput("midrst b_stall", {31'd0, b_stall}, 32'd0);
    checkOutput("midrst b_data_rd", b_data_rd, 32'd0);
    checkOutput("midrst b_rd_count", b_rd_count, 32'd0);
    checkOutput("midrst b_wr_count", b_wr_count, 32'd0);
    checkOutput("midrst a_rd_count", a_rd_count, 32'd0);
    write = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      exp_rd[s] = 32'd0;
      exp_wr[s] = 32'd0;
    end
    applyStimulus(1, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, "midrst_rd30", rdata);
    checkOutput("midrst_rd30 const", rdata, 32'h12345678);
    applyStimulus(1, 1'b1, 1'b1, 32'h40, 32'h5A5A5A5A, 4'hF, "b_both40", rdata);
    applyStimulus(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, "b_rd40", rdata);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 60; n++) begin
      int          s;
      int          op;
      logic [31:0] addr;
      s    = int'($urandom_range(0, 1));
      op   = int'($urandom_range(0, 2));
      addr = (32'($urandom_range(0, 3)) << ((s == 1) ? 12 : 15))
           | (32'($urandom_range(0, 15)) << 2)
           | 32'($urandom_range(0, 3));
      applyStimulus(s, (op != 1), (op != 0), addr, $urandom, 4'($urandom_range(0, 15)),
                    $sformatf("rand%0d", n), rdata);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
